// File: rtl/counter_t_sync.sv
// Modulo up/down counter built from per-bit toggle flip-flops.
// A synchronous load or reset overrides the toggle path.
// t_vec exposes which bits will flip on the coming edge.
// tc flags that the coming edge will wrap the count.

// One counter bit: a toggle flip-flop with synchronous clear and load.
// The complement is held in its own register rather than derived by an
// inverter, so q_inverse is a true registered output.
module counter_t_sync_tff (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic ld_val,
  input  logic t,
  output logic q,
  output logic qn
);

  // Priority inside the bit: clear, then load, then toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= 1'b0;
      qn <= 1'b1;
    end else if (load) begin
      q  <= ld_val;
      qn <= ~ld_val;
    end else if (t) begin
      q  <= ~q;
      qn <= ~qn;
    end
  end

endmodule

module counter_t_sync #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc
);

  // Largest legal count. It always fits in WIDTH bits because
  // MODULUS is at most 2^WIDTH.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             cnt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_val;

  // Count target and toggle enables.
  // Loads of out-of-range values are forced to zero, so q never leaves
  // the range 0..MODULUS-1.
  always_comb begin
    cnt = en && !load && !reset;
    if (up) nxt = (q == MAX)   ? '0  : q + WIDTH'(1);
    else    nxt = (q == '0)    ? MAX : q - WIDTH'(1);
    ld_val = (32'(d) < MODULUS) ? d : '0;
    t_vec  = cnt ? (q ^ nxt) : '0;
    tc     = cnt && (up ? (q == MAX) : (q == '0));
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      counter_t_sync_tff u_bit (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .ld_val (ld_val[i]),
        .t      (t_vec[i]),
        .q      (q[i]),
        .qn     (q_inverse[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_counter_t_sync.sv
// Bench for counter_t_sync.
// Instance A is WIDTH=4, MODULUS=10. Instance B is WIDTH=4, MODULUS=16.
// Fixed vector tables, hand-written corner sequences, and randomized
// traffic, all checked against an arithmetic modulo-counter model.
module tb_counter_t_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, ld_a = 1'b0, en_a = 1'b0, up_a = 1'b0;
  logic [3:0] d_a = '0, q_a, qi_a, tv_a;
  logic       tc_a;
  logic       rst_b = 1'b0, ld_b = 1'b0, en_b = 1'b0, up_b = 1'b0;
  logic [3:0] d_b = '0, q_b, qi_b, tv_b;
  logic       tc_b;

  counter_t_sync #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .up(up_a), .load(ld_a), .d(d_a),
    .q(q_a), .q_inverse(qi_a), .t_vec(tv_a), .tc(tc_a));

  counter_t_sync #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .up(up_b), .load(ld_b), .d(d_b),
    .q(q_b), .q_inverse(qi_b), .t_vec(tv_b), .tc(tc_b));

  int checks = 0;
  int failures = 0;
  int mq[2];
  int mods[2] = '{10, 16};

  typedef struct {
    bit rst; bit ld; int d; bit en; bit up;
    int exp_q; bit exp_tc;
  } vec_t;
  vec_t tbl[$];

  // Behavioural model: plain modulo arithmetic on integers.
  function automatic int m_next(int q, int mod, bit rst, bit ld, bit en,
                                bit up, int d);
    if (rst) return 0;
    if (ld)  return (d < mod) ? d : 0;
    if (en)  return up ? (q + 1) % mod : (q + mod - 1) % mod;
    return q;
  endfunction

  function automatic bit m_tc(int q, int mod, bit rst, bit ld, bit en, bit up);
    if (rst || ld || !en) return 1'b0;
    return up ? (q == mod - 1) : (q == 0);
  endfunction

  function automatic logic [3:0] m_tv(int q, int mod, bit rst, bit ld, bit en,
                                      bit up);
    int nc;
    if (rst || ld || !en) return 4'h0;
    nc = up ? (q + 1) % mod : (q + mod - 1) % mod;
    return 4'(q ^ nc);
  endfunction

  function automatic vec_t v(bit rst, bit ld, int d, bit en, bit up,
                             int eq, bit etc);
    vec_t r;
    r.rst = rst; r.ld = ld; r.d = d; r.en = en; r.up = up;
    r.exp_q = eq; r.exp_tc = etc;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle on instance w.
  // Comb outputs are checked mid-cycle; q and q_inverse are checked
  // just after the edge.
  task automatic step(int w, bit rst, bit ld, bit en, bit up, int d,
                      logic [3:0] exp_tv, bit exp_tc, int exp_q, string nm);
    if (w == 0) begin
      rst_a = rst; ld_a = ld; en_a = en; up_a = up; d_a = 4'(d);
    end else begin
      rst_b = rst; ld_b = ld; en_b = en; up_b = up; d_b = 4'(d);
    end
    #2;
    chk({nm, ".t_vec"}, (w == 0) ? int'(tv_a) : int'(tv_b), int'(exp_tv));
    chk({nm, ".tc"},    (w == 0) ? int'(tc_a) : int'(tc_b), int'(exp_tc));
    @(posedge clk); #1;
    chk({nm, ".q"},     (w == 0) ? int'(q_a)  : int'(q_b),  exp_q);
    chk({nm, ".q_inv"}, (w == 0) ? int'(qi_a) : int'(qi_b), (~exp_q) & 15);
    mq[w] = exp_q;
    if (w == 0) begin
      rst_a = 0; ld_a = 0; en_a = 0;
    end else begin
      rst_b = 0; ld_b = 0; en_b = 0;
    end
  endtask

  initial begin
    mq[0] = 0; mq[1] = 0;

    // Reset, then count up through the wrap (q = 1..9,0,1,2).
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 12; i++) tbl.push_back(v(0, 0, 0, 1, 1, i % 10, (i == 10)));

    // Down-count from 0 wraps to 9; tc is high before the first edge.
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 9, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 8, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 7, 0));

    // Loads win over en; an out-of-range load value becomes 0.
    tbl.push_back(v(0, 1, 7, 1, 1, 7, 0));
    tbl.push_back(v(0, 1, 12, 1, 0, 0, 0));

    // Count to 5, then reset with load and en also high; then idle.
    for (int i = 1; i <= 5; i++) tbl.push_back(v(0, 0, 0, 1, 1, i, 0));
    tbl.push_back(v(1, 1, 3, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0));

    // Direction change at q=4: sequence 4,5, then 4,3.
    for (int i = 1; i <= 5; i++) tbl.push_back(v(0, 0, 0, 1, 1, i, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 4, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 9, 0, 0, 3, 0));

    @(posedge clk); #1;
    foreach (tbl[k])
      step(0, tbl[k].rst, tbl[k].ld, tbl[k].en, tbl[k].up, tbl[k].d,
           m_tv(mq[0], 10, tbl[k].rst, tbl[k].ld, tbl[k].en, tbl[k].up),
           tbl[k].exp_tc, tbl[k].exp_q, $sformatf("tbl%0d", k));

    // Full-range instance: ripple toggle enables and wrap at 15.
    step(1, 1, 0, 0, 0, 0, 4'h0, 0, 0,  "b_rst");
    step(1, 0, 1, 1, 1, 7, 4'h0, 0, 7,  "b_ld7");
    step(1, 0, 0, 1, 1, 0, 4'hF, 0, 8,  "b_up7");
    step(1, 0, 0, 1, 1, 0, 4'h1, 0, 9,  "b_up8");
    step(1, 0, 1, 0, 0, 15, 4'h0, 0, 15, "b_ld15");
    step(1, 0, 0, 1, 1, 0, 4'hF, 1, 0,  "b_wrap");
    step(1, 0, 0, 1, 0, 0, 4'hF, 1, 15, "b_dnwrap");
    step(1, 0, 0, 1, 0, 0, 4'h1, 0, 14, "b_dn15");
    step(1, 0, 0, 1, 0, 0, 4'h3, 0, 13, "b_dn14");

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 400; n++) begin
      int  w, d;
      bit  rst, ld, en, up;
      w   = n & 1;
      rst = ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      d   = $urandom_range(0, 15);
      step(w, rst, ld, en, up, d,
           m_tv(mq[w], mods[w], rst, ld, en, up),
           m_tc(mq[w], mods[w], rst, ld, en, up),
           m_next(mq[w], mods[w], rst, ld, en, up, d),
           $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_t_sync.md
COUNTER_T_SYNC -- requirements
Module: counter_t_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter bit width, legal 1..16.
REQ-002 SHALL have parameter MODULUS, default 16: count modulus, legal 2..2^WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load request.
REQ-008 SHALL have port d  input  WIDTH  parallel load value.
REQ-009 SHALL have port q  output  WIDTH  registered count.
REQ-010 SHALL have port q_inverse  output  WIDTH  registered complement of q.
REQ-011 SHALL have port t_vec  output  WIDTH  combinational per-bit toggle enables for the coming edge.
REQ-012 SHALL have port tc  output  1  combinational terminal-count flag.

Function
REQ-013 SHALL apply priority reset > load > en at each rising edge of clk.
REQ-014 SHALL implement each q bit as a toggle flip-flop: q[i] inverts on the edge only when t_vec[i]=1, otherwise holds.
REQ-015 SHALL drive t_vec = q XOR next_count when en=1 and load=0, else all zeros.
REQ-016 SHALL produce, with en=1 and up=1: next_count = q+1, and MODULUS-1 wraps to 0.
REQ-017 SHALL produce, with en=1 and up=0: next_count = q-1, and 0 wraps to MODULUS-1.
REQ-018 SHALL, when MODULUS = 2^WIDTH, yield t_vec[i] = AND of q[i-1:0] (up) or AND of ~q[i-1:0] (down), with t_vec[0]=1.
REQ-019 SHALL hold q unchanged when en=0 and load=0.
REQ-020 SHALL, on load=1, set q = d when d < MODULUS, else q = 0, regardless of en/up.
REQ-021 SHALL keep q_inverse == ~q after every edge, including reset and load.
REQ-022 SHALL assert tc = en AND NOT load AND ((up AND q==MODULUS-1) OR (NOT up AND q==0)).
REQ-023 SHALL make direction changes take effect on the first edge after up changes, with no extra latency or skipped state.
REQ-024 SHALL have 1-cycle latency from en/load/d sampling to the updated q.
REQ-025 SHALL never let q hold a value >= MODULUS after any edge.

Reset
REQ-026 SHALL, on a rising edge with reset=1, set q = 0 and q_inverse = all ones, overriding load and en.
REQ-027 SHALL drive t_vec = 0 and tc = 0 while reset=1.
REQ-028 SHALL abandon any count or load in progress when reset is asserted mid-sequence; counting resumes from 0 on the first edge after reset deasserts with en=1.
REQ-029 SHALL leave q at X before the first reset edge; no initial-value dependence.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-030 SHALL verify: reset=1 for one edge, then en=1, up=1 for 12 edges -> q = 1..9,0,1,2; tc high only while q=9; q_inverse = ~q throughout.
REQ-031 SHALL verify: en=1, up=0 from q=0 -> q = 9,8,7; tc high while q=0 before the first edge.
REQ-032 SHALL verify: load=1 with d=7 and en=1 -> q=7, t_vec=0, tc=0 in the load cycle; load with d=12 -> q=0.
REQ-033 SHALL verify: MODULUS=16, up=1 from q=0111 -> t_vec=1111, then q=1000; from q=1111 -> q=0000, tc=1 before the edge.
REQ-034 SHALL verify: count to q=5, then assert reset with load=1, d=3, en=1 -> q=0, q_inverse=1111; en=0 for 3 edges -> q holds at 0.
REQ-035 SHALL verify: up toggled 1->0 at q=4 with en=1 -> q sequence 4,5 then 4,3 with no skipped or repeated value.
